// File: rtl/pll_lock_monitor.sv
// Digital phase/lock monitor: measures the signed delay between reference and PLL
// feedback rising edges in clk cycles and qualifies lock over consecutive comparisons.
module pll_lock_monitor #(
  parameter int CNT_W        = 16,
  parameter int TOL          = 2,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [CNT_W-1:0] phase_err,
  output logic             err_valid,
  output logic [CNT_W-1:0] ref_period,
  output logic             locked,
  output logic             miss
);

  typedef enum logic [1:0] {IDLE, REF_FIRST, FB_FIRST} state_t;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  TOL_VAL     = CNT_W'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(UNLOCK_COUNT);

  logic [1:0]        ref_sync;
  logic [1:0]        fb_sync;
  logic              ref_prev;
  logic              fb_prev;
  logic              ref_rise;
  logic              fb_rise;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout;

  logic              report;
  logic              report_neg;
  logic [CNT_W-1:0]  report_mag;
  logic              miss_now;
  logic              err_good;

  logic [CNT_W-1:0]  period_cnt;
  logic              period_valid;

  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_cnt_inc;
  logic [BAD_W-1:0]  bad_cnt;
  logic [BAD_W-1:0]  bad_cnt_inc;

  // Synchronizers stay live while disabled so a level held across enable is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_prev <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[0], ref_in};
      fb_sync  <= {fb_sync[0], fb_in};
      ref_prev <= ref_sync[1];
      fb_prev  <= fb_sync[1];
    end
  end

  assign ref_rise = ref_sync[1] & ~ref_prev;
  assign fb_rise  = fb_sync[1] & ~fb_prev;

  // cnt_inc is the edge-to-edge distance if the second edge lands this cycle.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = '0;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ref_rise && !fb_rise)      next_state = REF_FIRST;
          else if (fb_rise && !ref_rise) next_state = FB_FIRST;
        end
        REF_FIRST: begin
          if (ref_rise)                  next_state = REF_FIRST;
          else if (fb_rise || timeout)   next_state = IDLE;
          else                           cnt_next   = cnt_inc;
        end
        FB_FIRST: begin
          if (fb_rise)                   next_state = FB_FIRST;
          else if (ref_rise || timeout)  next_state = IDLE;
          else                           cnt_next   = cnt_inc;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A completing edge wins over a timeout landing in the same cycle.
  always_comb begin
    report     = 1'b0;
    report_neg = 1'b0;
    report_mag = '0;
    miss_now   = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          report = ref_rise & fb_rise;
        end
        REF_FIRST: begin
          if (fb_rise) begin
            report     = 1'b1;
            report_mag = cnt_inc;
          end else if (ref_rise || timeout) begin
            miss_now = 1'b1;
          end
        end
        FB_FIRST: begin
          if (ref_rise) begin
            report     = 1'b1;
            report_neg = 1'b1;
            report_mag = cnt_inc;
          end else if (fb_rise || timeout) begin
            miss_now = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_err <= '0;
      err_valid <= 1'b0;
      miss      <= 1'b0;
      err_good  <= 1'b0;
    end else begin
      err_valid <= report;
      miss      <= miss_now;
      if (report) begin
        phase_err <= report_neg ? ('0 - report_mag) : report_mag;
        err_good  <= (report_mag <= TOL_VAL);
      end
    end
  end

  // The first reference edge after reset or enable only arms the period measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt   <= '0;
      period_valid <= 1'b0;
      ref_period   <= '0;
    end else begin
      if (ref_rise)                  period_cnt <= CNT_W'(1);
      else if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_W'(1);
      if (!enable) begin
        period_valid <= 1'b0;
      end else if (ref_rise) begin
        period_valid <= 1'b1;
        if (period_valid) ref_period <= period_cnt;
      end
    end
  end

  assign good_cnt_inc = (good_cnt == GOOD_TARGET) ? good_cnt : good_cnt + GOOD_W'(1);
  assign bad_cnt_inc  = bad_cnt + BAD_W'(1);

  // Lock qualification acts on the registered result pulses, so locked trails them by one cycle.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
    end else if (err_valid && err_good) begin
      good_cnt <= good_cnt_inc;
      bad_cnt  <= '0;
      if (good_cnt_inc == GOOD_TARGET) locked <= 1'b1;
    end else if (miss || err_valid) begin
      good_cnt <= '0;
      if (locked) begin
        if (bad_cnt_inc == BAD_TARGET) begin
          locked  <= 1'b0;
          bad_cnt <= '0;
        end else begin
          bad_cnt <= bad_cnt_inc;
        end
      end
    end
  end

endmodule
